agu_fft_gen: RTL and testbench

Parametrised address generation unit for in-place radix-2 FFT.
- Per-stage data (butterfly operand) addresses or twiddle-factor addresses for one butterfly cell, streamed over a valid/ready port into the cell's memory read path.
- Successor to the fixed 1/2-butterfly AGU: supports up to 2^BU_LOG2_MAX parallel cells, run-time FFT size, inter-address delay gaps, output backpressure, abort, and stage/last tagging.

---
 rtl/agu_fft_pkg.sv | 23 ++
 rtl/agu_fft_addr_map.sv | 34 +++
 rtl/agu_fft_gen.sv | 200 ++++++++++++++++++++
 tb/tb_agu_fft_gen.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/agu_fft_pkg.sv
// Shared types for the radix-2 FFT address generation unit.
// Holds the FSM state and mode enums, plus the flags of the captured configuration.
package agu_fft_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } state_e;

  typedef enum logic {
    MODE_TWID = 1'b0,
    MODE_DATA = 1'b1
  } mode_e;

  // Width-independent part of the captured configuration; ok marks a usable config.
  typedef struct packed {
    logic  ok;
    mode_e mode;
    logic  even_odd;
  } cfg_t;

endpackage

// File: rtl/agu_fft_addr_map.sv
// Combinational mapping from (butterfly index k, stage s) to a data or twiddle address.
// Data: insert even_odd at bit s of k. Twiddle: low s bits of k scaled to the stage.
module agu_fft_addr_map #(
  parameter int ADDR_WIDTH  = 16,
  parameter int STAGE_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0]  k,
  input  logic [STAGE_WIDTH-1:0] s,
  input  logic [STAGE_WIDTH-1:0] l,
  input  logic                   even_odd,
  input  logic                   mode,
  output logic [ADDR_WIDTH-1:0]  addr
);

  logic [ADDR_WIDTH-1:0]  low_mask;
  logic [ADDR_WIDTH-1:0]  l_mask;
  logic [ADDR_WIDTH-1:0]  data_addr;
  logic [ADDR_WIDTH-1:0]  twid_addr;
  logic [STAGE_WIDTH-1:0] twid_shift;

  // NOTE: every signal assigned in this block gets a value on every path, so no latch is inferred.
  always_comb begin
    low_mask   = (ADDR_WIDTH'(1) << s) - ADDR_WIDTH'(1);
    l_mask     = (l >= STAGE_WIDTH'(ADDR_WIDTH)) ? '1
                                                  : (ADDR_WIDTH'(1) << l) - ADDR_WIDTH'(1);
    twid_shift = l - s - STAGE_WIDTH'(1);
    data_addr  = ((k >> s) << (s + STAGE_WIDTH'(1)))
               | (ADDR_WIDTH'(even_odd) << s)
               | (k & low_mask);
    twid_addr  = (k & low_mask) << twid_shift;
    addr       = (mode ? data_addr : twid_addr) & l_mask;
  end

endmodule

// File: rtl/agu_fft_gen.sv
// Radix-2 in-place FFT address generator for one butterfly cell out of 2^bu_log2.
// Streams per-stage data or twiddle addresses over valid/ready with optional gaps.
module agu_fft_gen
  import agu_fft_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int STAGE_WIDTH = 5,
  parameter int DELAY_WIDTH = 5,
  parameter int BU_LOG2_MAX = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               load_config,
  input  logic [STAGE_WIDTH-1:0]             log2_n,
  input  logic [$clog2(BU_LOG2_MAX+1)-1:0]   bu_log2,
  input  logic [BU_LOG2_MAX-1:0]             bu_index,
  input  logic                               mode,
  input  logic                               even_odd,
  input  logic [DELAY_WIDTH-1:0]             delay,
  input  logic                               start,
  input  logic                               abort,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [ADDR_WIDTH-1:0]              out_addr,
  output logic [STAGE_WIDTH-1:0]             out_stage,
  output logic                               out_last,
  output logic                               busy,
  output logic                               done,
  output logic                               cfg_err
);

  localparam int BW = $clog2(BU_LOG2_MAX + 1);

  state_e                 state;
  cfg_t                   cfg;
  logic [STAGE_WIDTH-1:0] cfg_l;
  logic [BW-1:0]          cfg_bu_log2;
  logic [BU_LOG2_MAX-1:0] cfg_bu_index;
  logic [DELAY_WIDTH-1:0] cfg_delay;

  logic [ADDR_WIDTH-1:0]  j;
  logic [STAGE_WIDTH-1:0] s;
  logic [DELAY_WIDTH-1:0] gap_cnt;

  logic                   cfg_bad;
  logic [STAGE_WIDTH-1:0] b_shift;
  logic [ADDR_WIDTH-1:0]  b_last;
  logic [ADDR_WIDTH-1:0]  k_base;
  logic                   j_last;
  logic                   s_last;
  logic [ADDR_WIDTH-1:0]  adv_j;
  logic [STAGE_WIDTH-1:0] adv_s;
  logic [ADDR_WIDTH-1:0]  map_j;
  logic [STAGE_WIDTH-1:0] map_s;
  logic                   map_last;
  logic [ADDR_WIDTH-1:0]  map_addr;
  logic                   accept;

  always_comb begin
    cfg_bad = (log2_n == '0)
           || (log2_n > STAGE_WIDTH'(ADDR_WIDTH))
           || (bu_log2 > BW'(BU_LOG2_MAX))
           || (STAGE_WIDTH'(bu_log2) >= log2_n)
           || ((bu_index >> bu_log2) != '0);
  end

  // B = 2^b_shift butterflies per stage; this cell owns k = bu_index*B + j.
  always_comb begin
    b_shift = cfg_l - STAGE_WIDTH'(cfg_bu_log2) - STAGE_WIDTH'(1);
    b_last  = (ADDR_WIDTH'(1) << b_shift) - ADDR_WIDTH'(1);
    k_base  = ADDR_WIDTH'(cfg_bu_index) << b_shift;
    j_last  = (j == b_last);
    s_last  = (s == cfg_l - STAGE_WIDTH'(1));
    adv_j   = j_last ? '0 : j + ADDR_WIDTH'(1);
    adv_s   = j_last ? s + STAGE_WIDTH'(1) : s;
    accept  = out_valid & out_ready;
    // In EMIT the address register is reloaded with the successor; elsewhere j/s already point at it.
    map_j    = (state == EMIT) ? adv_j : j;
    map_s    = (state == EMIT) ? adv_s : s;
    map_last = (map_j == b_last);
  end

  agu_fft_addr_map #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STAGE_WIDTH(STAGE_WIDTH)
  ) u_addr_map (
    .k       (k_base | map_j),
    .s       (map_s),
    .l       (cfg_l),
    .even_odd(cfg.even_odd),
    .mode    (cfg.mode),
    .addr    (map_addr)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      // NOTE: config registers are reset too; a zero config is invalid, so start is ignored until a load.
      cfg          <= '0;
      cfg_l        <= '0;
      cfg_bu_log2  <= '0;
      cfg_bu_index <= '0;
      cfg_delay    <= '0;
      cfg_err      <= 1'b0;
      j            <= '0;
      s            <= '0;
      gap_cnt      <= '0;
      out_valid    <= 1'b0;
      out_addr     <= '0;
      out_stage    <= '0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        busy      <= 1'b0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        out_addr  <= '0;
        out_stage <= '0;
        j         <= '0;
        s         <= '0;
        gap_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (load_config) begin
              cfg_l        <= log2_n;
              cfg_bu_log2  <= bu_log2;
              cfg_bu_index <= bu_index;
              cfg_delay    <= delay;
              cfg.mode     <= mode_e'(mode);
              cfg.even_odd <= even_odd;
              cfg.ok       <= ~cfg_bad;
              cfg_err      <= cfg_bad;
            end
            if (start && cfg.ok) begin
              state     <= EMIT;
              busy      <= 1'b1;
              out_valid <= 1'b1;
              out_addr  <= map_addr;
              out_stage <= map_s;
              out_last  <= map_last;
            end
          end

          EMIT: begin
            if (accept) begin
              if (j_last && s_last) begin
                state     <= IDLE;
                busy      <= 1'b0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                done      <= 1'b1;
                j         <= '0;
                s         <= '0;
              end else begin
                j <= adv_j;
                s <= adv_s;
                if (cfg_delay == '0) begin
                  out_addr  <= map_addr;
                  out_stage <= map_s;
                  out_last  <= map_last;
                end else begin
                  state     <= GAP;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  gap_cnt   <= cfg_delay;
                end
              end
            end
          end

          GAP: begin
            if (gap_cnt == DELAY_WIDTH'(1)) begin
              state     <= EMIT;
              out_valid <= 1'b1;
              out_addr  <= map_addr;
              out_stage <= map_s;
              out_last  <= map_last;
              gap_cnt   <= '0;
            end else begin
              gap_cnt <= gap_cnt - DELAY_WIDTH'(1);
            end
          end

          default: begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_agu_fft_gen.sv
// Self-checking bench for agu_fft_gen: directed cases plus randomized runs
// compared against an arithmetic model of the address sequence.
module tb_agu_fft_gen;

  localparam int AW = 16;
  localparam int SW = 5;
  localparam int DW = 5;
  localparam int BM = 2;
  localparam int BW = $clog2(BM + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_config;
  logic [SW-1:0] log2_n;
  logic [BW-1:0] bu_log2;
  logic [BM-1:0] bu_index;
  logic          mode;
  logic          even_odd;
  logic [DW-1:0] delay;
  logic          start;
  logic          abort;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [SW-1:0] out_stage;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          cfg_err;

  agu_fft_gen #(
    .ADDR_WIDTH (AW),
    .STAGE_WIDTH(SW),
    .DELAY_WIDTH(DW),
    .BU_LOG2_MAX(BM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_config(load_config),
    .log2_n     (log2_n),
    .bu_log2    (bu_log2),
    .bu_index   (bu_index),
    .mode       (mode),
    .even_odd   (even_odd),
    .delay      (delay),
    .start      (start),
    .abort      (abort),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_stage  (out_stage),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int stage;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic bit model_invalid(int l, int bl, int bi);
    return (l < 1) || (l > AW) || (bl > BM) || (bl > l - 1) || (bi >= (1 << bl));
  endfunction

  // Address sequence straight from the FFT indexing rules.
  function automatic void model_build(int l, int bl, int bi, int m, int eo);
    int nb, k, a;
    exp_t e;
    exp_q.delete();
    nb = 1 << (l - 1 - bl);
    for (int st = 0; st < l; st++) begin
      for (int jj = 0; jj < nb; jj++) begin
        k = bi * nb + jj;
        if (m == 1) a = ((k >> st) << (st + 1)) | (eo << st) | (k & ((1 << st) - 1));
        else        a = (k & ((1 << st) - 1)) << (l - 1 - st);
        e.addr  = a & ((1 << l) - 1);
        e.stage = st;
        e.last  = (jj == nb - 1);
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic load(input int l, input int bl, input int bi, input int m, input int eo, input int d);
    @(negedge clk);
    log2_n      = SW'(l);
    bu_log2     = BW'(bl);
    bu_index    = BM'(bi);
    mode        = 1'(m);
    even_odd    = 1'(eo);
    delay       = DW'(d);
    load_config = 1'b1;
    @(negedge clk);
    load_config = 1'b0;
    check("cfg_err", 64'(cfg_err), 64'(model_invalid(l, bl, bi)));
  endtask

  // rmode: 0 = ready held high, 1 = random ready, 2 = ready toggling.
  task automatic run(input int l, input int bl, input int bi, input int m, input int eo,
                     input int d, input int rmode);
    int             cycles = 0;
    int             idle = 0;
    bit             exp_done = 0, gap_pend = 0, hold_pend = 0, spurious = 0, finished = 0;
    logic [AW+SW:0] held = '0;
    exp_t           e;
    model_build(l, bl, bi, m, eo);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_latency", 64'(out_valid), 64'd1);
    while (cycles < 20000) begin
      if (exp_done) begin
        check("done_pulse", 64'(done), 64'd1);
        check("busy_after_done", 64'(busy), 64'd0);
        finished = 1;
        break;
      end
      if (done) spurious = 1;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = ~out_ready;
      endcase
      start = ($urandom_range(0, 7) == 0);
      if (hold_pend) begin
        check("hold_stable", 64'({out_valid, out_addr, out_stage, out_last}), 64'({1'b1, held}));
        hold_pend = 0;
      end
      if (out_valid) begin
        if (gap_pend) begin
          check("gap_len", 64'(idle), 64'(d));
          gap_pend = 0;
        end
        if (out_ready) begin
          e = exp_q.pop_front();
          check("addr", 64'(out_addr), 64'(e.addr));
          check("stage", 64'(out_stage), 64'(e.stage));
          check("last", 64'(out_last), 64'(e.last));
          if (exp_q.size() == 0) exp_done = 1;
          else begin
            gap_pend = 1;
            idle     = 0;
          end
        end else begin
          hold_pend = 1;
          held      = {out_addr, out_stage, out_last};
        end
      end else if (gap_pend) begin
        idle++;
      end
      cycles++;
      @(negedge clk);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check("run_complete", 64'(finished), 64'd1);
    check("no_early_done", 64'(spurious), 64'd0);
  endtask

  task automatic check_start_ignored(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check(tag, 64'({out_valid, busy}), 64'd0);
  endtask

  int  rl, rbl, rbi, rm, reo, rd, rr;
  bit  seen;

  initial begin
    rst_n = 1'b0; load_config = 1'b0; log2_n = '0; bu_log2 = '0; bu_index = '0;
    mode = 1'b0; even_odd = 1'b0; delay = '0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    #13;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_addr", 64'(out_addr), 64'd0);
    check("rst_out_stage", 64'(out_stage), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_start_ignored("start_without_config");

    // Data, upper then lower operand; twiddle single cell and cell 1 of 2; gapped run.
    load(3, 0, 0, 1, 0, 0); run(3, 0, 0, 1, 0, 0, 0);
    load(3, 0, 0, 1, 1, 0); run(3, 0, 0, 1, 1, 0, 0);
    load(3, 0, 0, 0, 0, 0); run(3, 0, 0, 0, 0, 0, 0);
    load(3, 1, 1, 0, 0, 0); run(3, 1, 1, 0, 0, 0, 0);
    load(3, 0, 0, 1, 0, 2); run(3, 0, 0, 1, 0, 2, 2);
    load(1, 0, 0, 1, 1, 0); run(1, 0, 0, 1, 1, 0, 1);
    load(4, 2, 3, 1, 0, 1); run(4, 2, 3, 1, 0, 1, 1);

    // Abort in stage 1 together with start and an accept; abort must win.
    load(3, 0, 0, 1, 0, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid && out_stage == SW'(1)) break;
      @(negedge clk);
    end
    check("abort_reached_stage1", 64'(out_stage), 64'd1);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_valid", 64'(out_valid), 64'd0);
    seen = done;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen |= done;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    run(3, 0, 0, 1, 0, 0, 0);

    // Invalid configurations, each followed by an ignored start.
    load(1, 1, 0, 1, 0, 0); check_start_ignored("start_bad_bu_vs_l");
    load(0, 0, 0, 1, 0, 0); check_start_ignored("start_l_zero");
    load(17, 0, 0, 1, 0, 0);
    load(3, 1, 2, 1, 0, 0);
    load(2, 2, 0, 1, 0, 0);
    load(5, 3, 0, 1, 0, 0); check_start_ignored("start_bu_too_big");
    load(16, 2, 0, 1, 0, 0);

    for (int i = 0; i < 20; i++) begin
      rl  = $urandom_range(1, 6);
      rbl = $urandom_range(0, (rl - 1 < BM) ? rl - 1 : BM);
      rbi = $urandom_range(0, (1 << rbl) - 1);
      rm  = $urandom_range(0, 1);
      reo = $urandom_range(0, 1);
      rd  = $urandom_range(0, 3);
      rr  = $urandom_range(0, 2);
      load(rl, rbl, rbi, rm, reo, rd);
      run(rl, rbl, rbi, rm, reo, rd, rr);
    end

    // Reset mid-run clears outputs asynchronously.
    load(4, 0, 0, 1, 0, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outputs",
          64'({out_valid, out_addr, out_stage, out_last, busy, done, cfg_err}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_start_ignored("start_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
